dual_req_arbiter: RTL and testbench

DUAL_REQ_ARBITER -- requirements
Module: dual_req_arbiter

---
 rtl/arb_pkg.sv | 36 +++
 rtl/arb_hold_cnt.sv | 38 +++
 rtl/dual_req_arbiter.sv | 115 +++++++++++
 tb/tb_dual_req_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the two-requester arbiter.
//   arb_state_e : 2-bit FSM state encoding (IDLE=0, GNT1=1, GNT2=2, RELEASE=3)
//   OWN1/OWN2   : last-owner codes used for the tie-break
//   arb_out_t   : bundle of the registered arbiter outputs
//   arb_decode  : state -> output decode (outputs depend on state only)
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT1    = 2'd1,
    GNT2    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWN1 = 2'd1;
  localparam logic [1:0] OWN2 = 2'd2;

  typedef struct packed {
    logic gnt1;
    logic gnt2;
    logic busy;
  } arb_out_t;

  function automatic arb_out_t arb_decode(input arb_state_e s);
    arb_out_t o;
    o = '0;
    case (s)
      GNT1:    begin o.gnt1 = 1'b1; o.busy = 1'b1; end
      GNT2:    begin o.gnt2 = 1'b1; o.busy = 1'b1; end
      RELEASE: o.busy = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/arb_hold_cnt.sv
// arb_hold_cnt: counts consecutive grant cycles and flags the last allowed one.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   clr     : clear the count (arbiter not in a grant state)
//   en      : count this cycle (arbiter in a grant state)
//   expired : current cycle is grant cycle number MAX_HOLD
module arb_hold_cnt #(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  // Count value k means this is grant cycle k+1; the forced release is
  // decided in the MAX_HOLD-th cycle so the grant lasts exactly MAX_HOLD.
  assign expired = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dual_req_arbiter.sv
// dual_req_arbiter: two-requester arbiter with alternating tie-break and a
// one-cycle bus-turnaround gap after each grant.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   req1    : requester 1 request (held while the resource is needed)
//   req2    : requester 2 request
//   gnt1    : registered grant to requester 1
//   gnt2    : registered grant to requester 2
//   busy    : registered, high in every state except IDLE
//   timeout : registered one-cycle pulse on a forced release
// Optional feature macro ARB_TIMEOUT_EN: bounds a grant to MAX_HOLD cycles.
// Without it the hold counter is absent, timeout is 0 and grants are unbounded.
module dual_req_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  output logic gnt1,
  output logic gnt2,
  output logic busy,
  output logic timeout
);

  if ((1 << CW) <= MAX_HOLD) begin : g_bad_cw
    $error("dual_req_arbiter: CW too small for MAX_HOLD");
  end

  arb_state_e state_q, state_d;
  logic [1:0] last_owner_q, last_owner_d;
  arb_out_t   out_q, out_d;
  logic       timeout_q;
  logic       in_grant;
  logic       expired;
  logic       forced;

  assign in_grant = (state_q == GNT1) || (state_q == GNT2);

`ifdef ARB_TIMEOUT_EN
  arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD),
    .CW       (CW)
  ) u_hold_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_grant),
    .en      (in_grant),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Next-state logic. A held grant is never preempted by the other side;
  // only its own request dropping (or expiry) ends it.
  always_comb begin
    state_d = IDLE;
    forced  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req1 && req2)  state_d = (last_owner_q == OWN1) ? GNT2 : GNT1;
        else if (req1)     state_d = GNT1;
        else if (req2)     state_d = GNT2;
        else               state_d = IDLE;
      end
      GNT1: begin
        if (expired)       begin state_d = RELEASE; forced = 1'b1; end
        else if (!req1)    state_d = RELEASE;
        else               state_d = GNT1;
      end
      GNT2: begin
        if (expired)       begin state_d = RELEASE; forced = 1'b1; end
        else if (!req2)    state_d = RELEASE;
        else               state_d = GNT2;
      end
      RELEASE:             state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Owner changes only on entry into a grant state, so a forced release
  // leaves it pointing at the timed-out side and the other side wins a tie.
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_d == GNT1 && state_q != GNT1) last_owner_d = OWN1;
    if (state_d == GNT2 && state_q != GNT2) last_owner_d = OWN2;
  end

  assign out_d = arb_decode(state_d);

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN2;
      out_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      out_q        <= out_d;
      timeout_q    <= forced;
    end
  end

  assign gnt1    = out_q.gnt1;
  assign gnt2    = out_q.gnt2;
  assign busy    = out_q.busy;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_dual_req_arbiter.sv
module tb_dual_req_arbiter;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst, req1, req2;
  logic gnt1, gnt2, busy, timeout;
  int   total = 0;
  int   bad   = 0;

  dual_req_arbiter #(.MAX_HOLD(16), .CW(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .req1    (req1),
    .req2    (req2),
    .gnt1    (gnt1),
    .gnt2    (gnt2),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // {gnt1,gnt2,busy,timeout}
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {gnt1, gnt2, busy, timeout};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Whole-run invariants, sampled away from the active edge.
  always @(negedge clk) begin
    total++;
    assert (!(gnt1 && gnt2)) else begin
      bad++;
      $error("FAIL mutex observed=%b%b expected=not both", gnt1, gnt2);
    end
`ifndef ARB_TIMEOUT_EN
    total++;
    assert (timeout === 1'b0) else begin
      bad++;
      $error("FAIL timeout_tied observed=%b expected=0", timeout);
    end
`endif
  end

  initial begin
    // Reset state
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0;
    tick(); tick();
    chk("reset_outs", 4'b0000);
    total++;
    assert (dut.last_owner_q === 2'd2) else begin
      bad++; $error("FAIL reset_owner observed=%0d expected=2", dut.last_owner_q);
    end
    total++;
    assert (dut.state_q === IDLE) else begin
      bad++; $error("FAIL reset_state observed=%0d expected=0", dut.state_q);
    end
    rst = 1'b0;

    // Single request: 1-cycle latency, hold, release gap, idle
    req1 = 1'b1; tick();
    chk("single_gnt", 4'b1010);
    tick(); tick(); tick();
    chk("single_hold", 4'b1010);
    req1 = 1'b0; tick();
    chk("single_release", 4'b0010);
    tick();
    chk("single_idle", 4'b0000);

    // Tie alternation from a fresh reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req1 = 1'b1; req2 = 1'b1; tick();
      chk((i % 2 == 0) ? "tie_gnt1" : "tie_gnt2", (i % 2 == 0) ? 4'b1010 : 4'b0110);
      req1 = 1'b0; req2 = 1'b0; tick();
      chk("tie_release", 4'b0010);
      tick();
    end
    chk("tie_idle", 4'b0000);

    // No preemption of a held grant
    req2 = 1'b1; tick();
    chk("nopre_gnt2", 4'b0110);
    req1 = 1'b1; tick(); tick(); tick();
    chk("nopre_hold", 4'b0110);
    req2 = 1'b0; tick();
    chk("nopre_release", 4'b0010);
    tick();
    chk("nopre_idle", 4'b0000);
    tick();
    chk("nopre_gnt1", 4'b1010);
    req1 = 1'b0; tick(); tick();

    // Reset mid-grant drops straight to IDLE; next tie goes to req1
    do_reset();
    req1 = 1'b1; tick();
    chk("rstmid_gnt1", 4'b1010);
    req2 = 1'b1; tick();
    chk("rstmid_gnt2_blocked", 4'b1010);
    rst = 1'b1; tick();
    chk("rstmid_drop", 4'b0000);
    total++;
    assert (dut.state_q === IDLE) else begin
      bad++; $error("FAIL rstmid_state observed=%0d expected=0", dut.state_q);
    end
    tick();
    chk("rst_priority", 4'b0000);
    rst = 1'b0; tick();
    chk("rstmid_tie_gnt1", 4'b1010);
    req1 = 1'b0; req2 = 1'b0; tick(); tick();

`ifdef ARB_TIMEOUT_EN
    // Forced release after 16 grant cycles, re-grant only through IDLE
    do_reset();
    req1 = 1'b1; tick();
    chk("to_gnt_first", 4'b1010);
    for (int i = 1; i < 16; i++) tick();
    chk("to_gnt_16th", 4'b1010);
    tick();
    chk("to_release_pulse", 4'b0011);
    tick();
    chk("to_idle", 4'b0000);
    tick();
    chk("to_regrant1", 4'b1010);
    // Second expiry with req2 pending: req2 wins the tie
    req2 = 1'b1;
    for (int i = 1; i < 16; i++) tick();
    chk("to2_gnt_16th", 4'b1010);
    tick();
    chk("to2_release_pulse", 4'b0011);
    tick();
    chk("to2_idle", 4'b0000);
    tick();
    chk("to2_gnt2", 4'b0110);
    req1 = 1'b0; req2 = 1'b0; tick(); tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
